ha_serial_add_ctrl: RTL and testbench
=====================================

# ha_serial_add_ctrl

Bit-serial adder controller that computes the WIDTH-bit sum of two operands with a single one-bit full-adder cell built from two half-adder cells. It accepts operands over a valid/ready handshake, processes one bit per cycle LSB-first with a registered carry, and presents sum and carry-out on a second valid/ready handshake. It sits between a requesting master and the shared half-adder datapath, giving minimal area at the cost of WIDTH-cycle latency.

## Interface
- WIDTH, 8: operand and sum width in bits, ≥1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands a/b valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A, sampled only on acceptance.
- b  in  WIDTH  operand B, sampled only on acceptance.
- out_valid  out  1  sum/cout valid; high only in DONE.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  (a+b) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. in_valid&in_ready at an edge: load a, b into shift registers, carry<=0, bit counter<=0, go RUN.
- RUN: each edge processes bit 0 of the shift registers: s = a0^b0^carry, c = (a0&b0)|((a0^b0)&carry), via cell. s shifts into sum register MSB end, shifting right; carry<=c; operand registers shift right; counter increments.
- RUN, counter==WIDTH-1 at an edge: final bit processed, cout<=c, go DONE.
- DONE: out_valid=1; sum/cout held stable. out_valid&out_ready at an edge: go IDLE. sum/cout keep last value in IDLE.
- in_valid outside IDLE ignored (in_ready=0); master holds operands per handshake.
- out_ready while out_valid=0: no effect.
- Overflow: sum wraps modulo 2^WIDTH; carry reported only on cout.
- Counter width max(1, $clog2(WIDTH)); no wrap beyond WIDTH-1.

## Timing
- Reset (rst_n low, async): state=IDLE, sum=0, cout=0, out_valid=0, busy=0, carry/counter/shift regs=0; in_ready=1 immediately.
- Acceptance edge = edge 0. Bit i processed at edge i+1. DONE entered at edge WIDTH; out_valid high in the following cycle.
- Latency acceptance→out_valid: WIDTH edges.
- Minimum spacing between acceptances: WIDTH+2 edges (RUN WIDTH, DONE ≥1, IDLE ≥1); no acceptance in the same cycle as the output handshake.
- in_ready, out_valid, busy decoded from registered state only; no combinational in→out paths.
- Reset mid-RUN or mid-DONE: operation aborted, no out_valid, outputs to reset values.
- WIDTH=1: DONE entered at edge 1.

## Structure
- Package ha_pkg: state enum typedef (IDLE, RUN, DONE, 2-bit encoding).
- Sub-module serial_fa_cell: combinational one-bit full adder from two HalfAdder instances plus OR for carry; instantiated once.
- Top holds FSM, counter, operand/sum shift registers, carry flop.

## Test plan
- Reset: assert rst_n low mid-cycle → sum=0, cout=0, out_valid=0, busy=0, in_ready=1 without clock edge.
- WIDTH=8, a=0x35, b=0x4A → sum=0x7F, cout=0; out_valid rises exactly 8 edges after acceptance edge.
- a=0xFF, b=0x01 → sum=0x00, cout=1 (full-length carry ripple).
- Back-pressure: result 0x10+0x20, hold out_ready=0 for 5 cycles while driving in_valid with new operands → sum=0x30 stable, in_ready=0, new operands ignored; release → IDLE, then 0x80+0x80 → sum=0x00, cout=1.
- Reset at bit 3 of 0x0F+0x01 → no out_valid; after release 0x01+0x02 → sum=0x03, cout=0.
- WIDTH=1 build: a=1, b=1 → sum=0, cout=1, out_valid 1 edge after acceptance.

Source files
------------

// File: rtl/ha_pkg.sv
// Shared types and helpers for the bit-serial half-adder based adder controller.
package ha_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width: enough to count 0..w-1, never narrower than one bit
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/HalfAdder.sv
// One-bit half adder: sum and carry of two input bits.
module HalfAdder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Sum is the XOR of the inputs, carry is their AND
    always_comb begin
        s = a ^ b;
        c = a & b;
    end

endmodule

// File: rtl/serial_fa_cell.sv
// Combinational one-bit full adder built from two half adders and an OR.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    HalfAdder u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    HalfAdder u_ha1 (
        .a (s1),
        .b (cin),
        .s (s),
        .c (c2)
    );

    // Carry out is generated by either half adder
    always_comb begin
        cout = c1 | c2;
    end

endmodule

// File: rtl/ha_serial_add_ctrl.sv
// Bit-serial adder controller: accepts two WIDTH-bit operands, adds them
// LSB-first one bit per cycle through a single full-adder cell, and presents
// the sum and carry-out on a valid/ready output handshake.
module ha_serial_add_ctrl
    import ha_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;

    logic              fa_s;
    logic              fa_c;

    // Single shared full-adder cell working on the operand LSBs
    serial_fa_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // State, counter, shift registers and carry flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state and datapath update; everything holds unless a state acts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Shift right and insert the new sum bit at the MSB so that
                // after WIDTH steps bit 0 of the result lands at position 0.
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_s;
                carry_d          = fa_c;
                a_sh_d           = a_sh_q >> 1;
                b_sh_d           = b_sh_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    cout_d  = fa_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from registered state only
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
        sum       = sum_q;
        cout      = cout_q;
    end

endmodule

// File: tb/tb_ha_serial_add_ctrl.sv
// Self-checking bench for ha_serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_ha_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    logic         in_valid1;
    logic         out_ready1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         in_ready1;
    logic         out_valid1;
    logic [0:0]   sum1;
    logic         cout1;
    logic         busy1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ha_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    ha_serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .busy      (busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands and complete the input handshake; called at posedge+1
    task automatic start8(input logic [W-1:0] x, input logic [W-1:0] y);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("out_valid_after_accept", 32'(out_valid), 32'd0);
    endtask

    // Count edges after acceptance until out_valid, bounded
    task automatic wait_done8(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 4 * W) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Consume the result and confirm return to IDLE with result held
    task automatic finish8(input logic [W-1:0] es, input logic ec);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_consume", 32'(in_ready), 32'd1);
        check("busy_after_consume", 32'(busy), 32'd0);
        check("sum_held_idle", 32'(sum), 32'(es));
        check("cout_held_idle", 32'(cout), 32'(ec));
    endtask

    task automatic run8(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] es, input logic ec);
        int lat;
        start8(x, y);
        wait_done8(lat);
        check("latency", 32'(lat), 32'(W));
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(ec));
        finish8(es, ec);
    endtask

    task automatic run1(input logic x, input logic y, input logic es, input logic ec);
        int lat;
        check("w1_in_ready", 32'(in_ready1), 32'd1);
        a1        = x;
        b1        = y;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (out_valid1 !== 1'b1 && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("w1_latency", 32'(lat), 32'd1);
        check("w1_sum", 32'(sum1), 32'(es));
        check("w1_cout", 32'(cout1), 32'(ec));
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
        check("w1_in_ready_after", 32'(in_ready1), 32'd1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int           lat;
        int           seen;
        logic [W:0]   ref_full;
        logic [W-1:0] x;
        logic [W-1:0] y;

        vecs[0] = '{a: 8'h35, b: 8'h4A, s: 8'h7F, c: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
        vecs[2] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1};
        vecs[3] = '{a: 8'hAA, b: 8'h55, s: 8'hFF, c: 1'b0};
        vecs[4] = '{a: 8'hC8, b: 8'h64, s: 8'h2C, c: 1'b1};
        vecs[5] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0};
        vecs[6] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1};
        vecs[7] = '{a: 8'h01, b: 8'h02, s: 8'h03, c: 1'b0};

        rst_n      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        a1         = '0;
        b1         = '0;

        // Asynchronous reset, observed before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_w1_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
        end

        // Back-pressure: result held while new operands are ignored
        start8(8'h10, 8'h20);
        wait_done8(lat);
        check("bp_latency", 32'(lat), 32'(W));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 8'h77;
            b        = 8'h11;
            @(posedge clk);
            #1;
            check("bp_sum", 32'(sum), 32'h30);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        finish8(8'h30, 1'b0);
        run8(8'h80, 8'h80, 8'h00, 1'b1);

        // Reset while bit 3 is about to be processed
        start8(8'h0F, 8'h01);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_out_valid", 32'(seen), 32'd0);
        run8(8'h01, 8'h02, 8'h03, 1'b0);

        // Randomized operands against plain-arithmetic reference
        for (int i = 0; i < 40; i++) begin
            x        = W'($urandom);
            y        = W'($urandom);
            ref_full = {1'b0, x} + {1'b0, y};
            start8(x, y);
            wait_done8(lat);
            check("rnd_latency", 32'(lat), 32'(W));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
                check("rnd_hold_valid", 32'(out_valid), 32'd1);
                check("rnd_hold_sum", 32'(sum), 32'(ref_full[W-1:0]));
            end
            check("rnd_sum", 32'(sum), 32'(ref_full[W-1:0]));
            check("rnd_cout", 32'(cout), 32'(ref_full[W]));
            finish8(ref_full[W-1:0], ref_full[W]);
        end

        // WIDTH=1 instance
        run1(1'b1, 1'b1, 1'b0, 1'b1);
        run1(1'b1, 1'b0, 1'b1, 1'b0);
        run1(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
